fdiv_issue_ctrl: RTL

Issue controller for the fixed-latency, non-stallable single-precision divide pipeline (`fdiv_d`). Two requesters, the integer core's FPU issue port and the vector/loop helper, share the one divider through a round-robin arbiter. Each accepted operation carries a tag and a source ID down a valid/tag shift register aligned with the datapath. Results land in a credit-protected result FIFO, so back-pressure on the result port never drops a quotient.

---
 rtl/fpu_pkg.sv | 16 +
 rtl/fdiv_res_fifo.sv | 56 +++++
 rtl/fdiv_issue_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types: divider latency default, tag/source types and the result record.
// No logic; referenced by the divide issue controller and its result FIFO.
package fpu_pkg;
  localparam int FDIV_LAT  = 5;
  localparam int FDIV_TAGW = 5;

  typedef logic [FDIV_TAGW-1:0] tag_t;
  typedef logic                 src_t;

  typedef struct packed {
    logic [31:0] y;
    logic        ovf;
    tag_t        tag;
    src_t        src;
  } fdiv_res_t;
endpackage

// File: rtl/fdiv_res_fifo.sv
// Synchronous FIFO of divide results; head is combinational from storage, zero when empty.
// Latency: push visible at head next cycle; pop frees a slot next cycle; push to a full FIFO is dropped.
module fdiv_res_fifo import fpu_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  fdiv_res_t              push_dat_i,
  input  logic                   pop_i,
  output fdiv_res_t              head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  fdiv_res_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fdiv_issue_ctrl.sv
// Round-robin issue of two requesters into a fixed-latency divider, results queued in a credited FIFO.
// Latency: accept to res_valid is LAT+2; issue stalls when in-flight ops plus queued results reach DEPTH.
module fdiv_issue_ctrl import fpu_pkg::*; #(
  parameter int LAT   = FDIV_LAT,
  parameter int TAGW  = FDIV_TAGW,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [31:0]     req0_x1,
  input  logic [31:0]     req0_x2,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [31:0]     req1_x1,
  input  logic [31:0]     req1_x2,
  input  logic [TAGW-1:0] req1_tag,
  output logic [31:0]     div_x1,
  output logic [31:0]     div_x2,
  input  logic [31:0]     div_y,
  input  logic            div_ovf,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_y,
  output logic            res_ovf,
  output logic [TAGW-1:0] res_tag,
  output logic            res_src,
  output logic            busy
);
  // Stage 0 lines up with the operand register; stage k with divider stage k.
  localparam int NS = LAT + 1;
  localparam int CW = $clog2(DEPTH + NS + 1) + 1;

  logic [NS-1:0]         v_q;
  tag_t                  tag_q [NS];
  logic [NS-1:0]         src_q;
  logic                  prio_q, prio_d;
  logic [31:0]           x1_q, x1_d, x2_q, x2_d;
  logic [CW-1:0]         used;
  logic                  issue_ok, gnt0, gnt1;
  fdiv_res_t             fifo_in, fifo_head;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic                  fifo_full, fifo_empty;

  always_comb begin
    used = CW'(fifo_cnt);
    for (int i = 0; i < NS; i++) used = used + CW'(v_q[i]);
  end

  assign issue_ok   = !rst && (used < CW'(DEPTH));
  assign req0_ready = issue_ok && (!req1_valid || !prio_q);
  assign req1_ready = issue_ok && (!req0_valid || prio_q);
  assign gnt0       = req0_valid && req0_ready;
  assign gnt1       = req1_valid && req1_ready;

  always_comb begin
    prio_d = prio_q;
    x1_d   = x1_q;
    x2_d   = x2_q;
    if (gnt0) begin
      prio_d = 1'b1;
      x1_d   = req0_x1;
      x2_d   = req0_x2;
    end else if (gnt1) begin
      prio_d = 1'b0;
      x1_d   = req1_x1;
      x2_d   = req1_x2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      prio_q <= 1'b0;
      x1_q   <= '0;
      x2_q   <= '0;
    end else begin
      v_q    <= {v_q[NS-2:0], gnt0 || gnt1};
      prio_q <= prio_d;
      x1_q   <= x1_d;
      x2_q   <= x2_d;
    end
  end

  // Tag/source need no reset: they are only ever consumed alongside a set valid.
  always_ff @(posedge clk) begin
    tag_q[0] <= gnt1 ? tag_t'(req1_tag) : tag_t'(req0_tag);
    src_q[0] <= gnt1;
    for (int i = 1; i < NS; i++) begin
      tag_q[i] <= tag_q[i-1];
      src_q[i] <= src_q[i-1];
    end
  end

  assign fifo_in = '{y: div_y, ovf: div_ovf, tag: tag_q[NS-1], src: src_q[NS-1]};

  fdiv_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (v_q[NS-1]),
    .push_dat_i (fifo_in),
    .pop_i      (res_valid && res_ready),
    .head_o     (fifo_head),
    .count_o    (fifo_cnt),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assert property (@(posedge clk) disable iff (rst) !(v_q[NS-1] && fifo_full));

  assign div_x1    = x1_q;
  assign div_x2    = x2_q;
  assign res_valid = !fifo_empty;
  assign res_y     = fifo_head.y;
  assign res_ovf   = fifo_head.ovf;
  assign res_tag   = TAGW'(fifo_head.tag);
  assign res_src   = fifo_head.src;
  assign busy      = (|v_q) || !fifo_empty;
endmodule
